dp_controller: RTL
==================

// Module: dp_controller
// PURPOSE
// Multi-cycle control FSM that drives the ARM32 datapath control inputs for data-processing instructions.
// Accepts one 32-bit instruction over a valid/ready handshake and decodes it into register addresses,
// shifter/ALU selects and register enables. Reads back the datapath status word for condition checks.
// Sits between instruction fetch and the datapath; the datapath's enable/select inputs connect 1:1 to these outputs.
// PARAMETERS
// ALU_OP_W   3   width of ALU_op; encodings: ADD=000 SUB=001 AND=010 ORR=011 EOR=100 MOV=101 MVN=110 CMP=111
// PORTS
// clk          in   1   single clock, rising edge
// rst_n        in   1   asynchronous active-low reset
// instr        in   32  ARM data-processing instruction
// instr_valid  in   1   instr is valid this cycle
// instr_ready  out  1   controller can accept (high only in IDLE)
// status_in    in   32  datapath status_out; NZCV = [31:28]
// A_addr/B_addr/shift_addr/w_addr  out 4 each  = instr[19:16] / [3:0] / [11:8] / [15:12]
// en_A en_B en_S en_C en_status w_en  out 1 each  datapath register enables
// sel_A sel_B sel_shift wb_sel  out 1 each  datapath mux selects (wb_sel tied 0)
// shift_op     out  2   = instr[6:5]
// shift_imme   out  32  zero-extended instr[11:7]
// imme_data    out  32  instr[7:0] zero-extended, rotated right by 2*instr[11:8]
// ALU_op       out  3   per encoding above
// done         out  1   one-cycle pulse: instruction retired or skipped
// skipped      out  1   valid with done: condition failed or illegal opcode
// illegal      out  1   valid with done: opcode not supported
// BEHAVIOUR
// - Reset: state=IDLE, instruction register IR=0; all enables, done, skipped, illegal = 0; instr_ready=1.
// - Outputs are combinational from state and IR; IR loads only on handshake (instr_valid & instr_ready).
// - States: IDLE -> LOAD -> EXEC -> WB -> IDLE; LOAD -> IDLE directly on skip.
// - IDLE: instr_ready=1; handshake captures IR, go to LOAD. No handshake: stay in IDLE.
// - LOAD: evaluate cond IR[31:28] against status_in[31:28] and opcode IR[24:21].
//   Fail or illegal: done=1, skipped=1 (illegal=1 if opcode unsupported), no enables, go to IDLE.
//   Pass: en_A=1, en_B=1, en_S=1; go to EXEC.
// - Shift source: IR[25]=1 -> sel_B=1 (imme_data). IR[25]=0 -> sel_B=0; IR[4]=0 -> sel_shift=0 (shift_imme);
//   IR[4]=1 -> sel_shift=1 (shift register read).
// - sel_A=1 for MOV/MVN, 0 otherwise.
// - EXEC: en_C=1; en_status=1 if IR[20] (S) set or opcode is CMP; go to WB.
// - WB: w_en=1 unless CMP; done=1; go to IDLE.
// - Latency: handshake at cycle t -> done at t+3 (executed) or t+1 (skipped).
// - Opcode map (IR[24:21] -> ALU_op): 0000 AND, 0001 EOR, 0010 SUB, 0100 ADD, 1010 CMP, 1100 ORR, 1101 MOV,
//   1111 MVN. All other opcodes are illegal.
// - IR[27:26] != 00 is illegal.
// - Selects and addresses hold their decoded values in LOAD, EXEC and WB; they are 0 in IDLE.
// - rst_n low in any state: immediate return to IDLE, all outputs to reset values. In-flight instruction discarded, no done.
// - instr_valid high outside IDLE is ignored (instr_ready=0).
// CONFIGURATION
// COND_EXEC_EN defined: full ARM condition table (EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL);
//   NV (1111) is treated as always false.
// COND_EXEC_EN undefined: every instruction behaves as AL; status_in ignored by the FSM; skipped set only for illegal.
// TESTING
// - Reset mid-EXEC of ADD R1,R2,R3 -> next cycle IDLE, en_C=0, instr_ready=1, no done pulse.
// - ADD R1,R2,R3 (0xE0821003) valid in IDLE -> LOAD en_A/en_B/en_S, A=2 B=3; EXEC en_C, ALU_op=000;
//   WB w_en, w_addr=1, done.
// - MOV R0,#0xFF000000 (0xE3A004FF) -> sel_A=1, sel_B=1, imme_data=0xFF000000, ALU_op=101, done 3 cycles after accept.
// - CMP R4,R5 (0xE1540005) -> en_status=1 in EXEC, w_en=0 in WB, done=1.
// - COND_EXEC_EN, status_in[30]=0, ADDEQ (0x00821003) -> done=1, skipped=1 one cycle after accept, no enables.
// - Opcode 0011 (RSB, 0xE0621003) -> done=1, skipped=1, illegal=1 after LOAD; no datapath enables asserted.

Source files
------------

// File: rtl/dp_controller.sv
// dp_controller: multi-cycle control FSM for ARM32 data-processing ops.
// Optional macro COND_EXEC_EN enables the full ARM condition table.
module dp_controller #(
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [31:0]         status_in,
  output logic [3:0]          A_addr,
  output logic [3:0]          B_addr,
  output logic [3:0]          shift_addr,
  output logic [3:0]          w_addr,
  output logic                en_A,
  output logic                en_B,
  output logic                en_S,
  output logic                en_C,
  output logic                en_status,
  output logic                w_en,
  output logic                sel_A,
  output logic                sel_B,
  output logic                sel_shift,
  output logic                wb_sel,
  output logic [1:0]          shift_op,
  output logic [31:0]         shift_imme,
  output logic [31:0]         imme_data,
  output logic [ALU_OP_W-1:0] ALU_op,
  output logic                done,
  output logic                skipped,
  output logic                illegal
);

  typedef enum logic [1:0] {
    IDLE, LOAD, EXEC, WB
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;

  logic                legal;
  logic                is_cmp;
  logic                is_mov;
  logic                cond_ok;
  logic                skip;
  logic [ALU_OP_W-1:0] alu_dec;
  logic [63:0]         rot;

  // opcode decode to ALU select and legality
  always_comb begin
    legal   = 1'b1;
    alu_dec = '0;
    unique case (ir_q[24:21])
      4'b0000: alu_dec = ALU_OP_W'(3'b010);
      4'b0001: alu_dec = ALU_OP_W'(3'b100);
      4'b0010: alu_dec = ALU_OP_W'(3'b001);
      4'b0100: alu_dec = ALU_OP_W'(3'b000);
      4'b1010: alu_dec = ALU_OP_W'(3'b111);
      4'b1100: alu_dec = ALU_OP_W'(3'b011);
      4'b1101: alu_dec = ALU_OP_W'(3'b101);
      4'b1111: alu_dec = ALU_OP_W'(3'b110);
      default: legal   = 1'b0;
    endcase
    if (ir_q[27:26] != 2'b00) legal = 1'b0;
  end

  assign is_cmp = (ir_q[24:21] == 4'b1010);
  assign is_mov = (ir_q[24:21] == 4'b1101)
                | (ir_q[24:21] == 4'b1111);

`ifdef COND_EXEC_EN
  logic n_f, z_f, c_f, v_f;
  logic unused_status;
  assign {n_f, z_f, c_f, v_f} = status_in[31:28];
  assign unused_status = ^status_in[27:0];

  // ARM condition evaluation against live NZCV
  always_comb begin
    cond_ok = 1'b0;
    unique case (ir_q[31:28])
      4'h0: cond_ok = z_f;
      4'h1: cond_ok = ~z_f;
      4'h2: cond_ok = c_f;
      4'h3: cond_ok = ~c_f;
      4'h4: cond_ok = n_f;
      4'h5: cond_ok = ~n_f;
      4'h6: cond_ok = v_f;
      4'h7: cond_ok = ~v_f;
      4'h8: cond_ok = c_f & ~z_f;
      4'h9: cond_ok = ~c_f | z_f;
      4'hA: cond_ok = (n_f == v_f);
      4'hB: cond_ok = (n_f != v_f);
      4'hC: cond_ok = ~z_f & (n_f == v_f);
      4'hD: cond_ok = z_f | (n_f != v_f);
      4'hE: cond_ok = 1'b1;
      4'hF: cond_ok = 1'b0;
    endcase
  end
`else
  logic unused_status;
  assign unused_status = ^{status_in, ir_q[31:28]};
  assign cond_ok = 1'b1;
`endif

  assign skip = ~legal | ~cond_ok;
  assign rot  = {24'd0, ir_q[7:0], 24'd0, ir_q[7:0]}
              >> {ir_q[11:8], 1'b0};

  // state and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // next state; IR loads only on handshake
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE: if (instr_valid) begin
        state_d = LOAD;
        ir_d    = instr;
      end
      LOAD: state_d = skip ? IDLE : EXEC;
      EXEC: state_d = WB;
      WB:   state_d = IDLE;
    endcase
  end

  // outputs from state and IR
  always_comb begin
    instr_ready = 1'b0;
    A_addr      = '0;
    B_addr      = '0;
    shift_addr  = '0;
    w_addr      = '0;
    sel_A       = 1'b0;
    sel_B       = 1'b0;
    sel_shift   = 1'b0;
    wb_sel      = 1'b0;
    shift_op    = '0;
    shift_imme  = '0;
    imme_data   = '0;
    ALU_op      = '0;
    en_A        = 1'b0;
    en_B        = 1'b0;
    en_S        = 1'b0;
    en_C        = 1'b0;
    en_status   = 1'b0;
    w_en        = 1'b0;
    done        = 1'b0;
    skipped     = 1'b0;
    illegal     = 1'b0;
    if (state_q != IDLE) begin
      A_addr     = ir_q[19:16];
      B_addr     = ir_q[3:0];
      shift_addr = ir_q[11:8];
      w_addr     = ir_q[15:12];
      sel_A      = is_mov;
      sel_B      = ir_q[25];
      sel_shift  = ~ir_q[25] & ir_q[4];
      shift_op   = ir_q[6:5];
      shift_imme = {27'd0, ir_q[11:7]};
      imme_data  = rot[31:0];
      ALU_op     = alu_dec;
    end
    unique case (state_q)
      IDLE: instr_ready = 1'b1;
      LOAD: if (skip) begin
        done    = 1'b1;
        skipped = 1'b1;
        illegal = ~legal;
      end else begin
        en_A = 1'b1;
        en_B = 1'b1;
        en_S = 1'b1;
      end
      EXEC: begin
        en_C      = 1'b1;
        en_status = ir_q[20] | is_cmp;
      end
      WB: begin
        w_en = ~is_cmp;
        done = 1'b1;
      end
    endcase
  end

endmodule
